// File: rtl/bullet_hit_detector.sv
// rtl/bullet_hit_detector.sv - resolves the in-flight bullet against aliens and player; owns alive bitmap, score, lives
module bullet_hit_detector #(
  parameter int ROWS      = 5,
  parameter int COLS      = 11,
  parameter int COL_SHIFT = 5,
  parameter int ROW_SHIFT = 5,
  parameter int ALIEN_W   = 24,
  parameter int ALIEN_H   = 16,
  parameter int PLAYER_Y  = 450,
  parameter int PLAYER_W  = 26,
  parameter int PLAYER_H  = 16,
  parameter int POINTS    = 10,
  parameter int LIVES     = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [9:0]           bullet_x,
  input  logic [8:0]           bullet_y,
  input  logic                 bullet_active,
  input  logic                 bullet_dir,
  input  logic [9:0]           grid_x,
  input  logic [8:0]           grid_y,
  input  logic [9:0]           player_x,
  input  logic                 wave_reset,
  output logic                 bullet_kill,
  output logic                 alien_hit,
  output logic [2:0]           hit_row,
  output logic [3:0]           hit_col,
  output logic                 player_hit,
  output logic [ROWS*COLS-1:0] alive,
  output logic [15:0]          score,
  output logic [2:0]           lives,
  output logic                 all_dead,
  output logic                 game_over
);

  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, CHECK, RESOLVE, WAIT} state_t;

  state_t         state_q, state_d;
  logic [9:0]     x_q, x_d, gx_q, gx_d, px_q, px_d;
  logic [8:0]     y_q, y_d, gy_q, gy_d;
  logic           dir_q, dir_d;
  logic           pend_alien_q, pend_alien_d, pend_player_q, pend_player_d;
  logic [6:0]     pend_idx_q, pend_idx_d;
  logic [2:0]     pend_row_q, pend_row_d;
  logic [3:0]     pend_col_q, pend_col_d;
  logic [N-1:0]   alive_q, alive_d;
  logic [15:0]    score_q, score_d;
  logic [2:0]     lives_q, lives_d;
  logic [2:0]     hit_row_q, hit_row_d;
  logic [3:0]     hit_col_q, hit_col_d;

  logic [10:0]    dx;
  logic [9:0]     dy;
  logic [9:0]     col_w;
  logic [8:0]     row_w;
  logic [6:0]     idx;
  logic [127:0]   alive_pad;
  logic           a_hit, p_hit;
  logic [10:0]    x11, y11, px_end;
  logic [16:0]    score_sum;

  // Hit geometry from the registered sample only; a borrow in dx/dy means left of / above the grid
  always_comb begin
    dx        = {1'b0, x_q} - {1'b0, gx_q};
    dy        = {1'b0, y_q} - {1'b0, gy_q};
    col_w     = dx[9:0] >> COL_SHIFT;
    row_w     = dy[8:0] >> ROW_SHIFT;
    idx       = 7'(row_w[2:0]) * 7'(COLS) + 7'(col_w[3:0]);
    alive_pad = 128'(alive_q);
    a_hit     = dir_q && !dx[10] && !dy[9]
                && (col_w < 10'(COLS)) && (row_w < 9'(ROWS))
                && ({1'b0, dx[COL_SHIFT-1:0]} < (COL_SHIFT+1)'(ALIEN_W))
                && ({1'b0, dy[ROW_SHIFT-1:0]} < (ROW_SHIFT+1)'(ALIEN_H))
                && alive_pad[idx];
    x11       = {1'b0, x_q};
    y11       = {2'b0, y_q};
    px_end    = {1'b0, px_q} + 11'(PLAYER_W);
    p_hit     = !dir_q && (x11 >= {1'b0, px_q}) && (x11 < px_end)
                && (y11 >= 11'(PLAYER_Y)) && (y11 < 11'(PLAYER_Y + PLAYER_H));
    score_sum = {1'b0, score_q} + 17'(POINTS);
  end

  // Next-state and bookkeeping; wave_reset overrides any bitmap change made in the same cycle
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    dir_d         = dir_q;
    gx_d          = gx_q;
    gy_d          = gy_q;
    px_d          = px_q;
    pend_alien_d  = pend_alien_q;
    pend_player_d = pend_player_q;
    pend_idx_d    = pend_idx_q;
    pend_row_d    = pend_row_q;
    pend_col_d    = pend_col_q;
    alive_d       = alive_q;
    score_d       = score_q;
    lives_d       = lives_q;
    hit_row_d     = hit_row_q;
    hit_col_d     = hit_col_q;
    case (state_q)
      IDLE: begin
        if (bullet_active && !game_over) begin
          x_d     = bullet_x;
          y_d     = bullet_y;
          dir_d   = bullet_dir;
          gx_d    = grid_x;
          gy_d    = grid_y;
          px_d    = player_x;
          state_d = CHECK;
        end
      end
      CHECK: begin
        pend_alien_d  = a_hit;
        pend_player_d = p_hit;
        pend_idx_d    = idx;
        pend_row_d    = row_w[2:0];
        pend_col_d    = col_w[3:0];
        state_d       = (a_hit || p_hit) ? RESOLVE : IDLE;
      end
      RESOLVE: begin
        if (pend_alien_q && !wave_reset) begin
          for (int i = 0; i < N; i++) begin
            if (7'(i) == pend_idx_q) alive_d[i] = 1'b0;
          end
          score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          hit_row_d = pend_row_q;
          hit_col_d = pend_col_q;
        end
        if (pend_player_q && (lives_q != 3'd0)) lives_d = lives_q - 3'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (!bullet_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wave_reset) alive_d = '1;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      dir_q         <= 1'b0;
      gx_q          <= '0;
      gy_q          <= '0;
      px_q          <= '0;
      pend_alien_q  <= 1'b0;
      pend_player_q <= 1'b0;
      pend_idx_q    <= '0;
      pend_row_q    <= '0;
      pend_col_q    <= '0;
      alive_q       <= '1;
      score_q       <= '0;
      lives_q       <= 3'(LIVES);
      hit_row_q     <= '0;
      hit_col_q     <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dir_q         <= dir_d;
      gx_q          <= gx_d;
      gy_q          <= gy_d;
      px_q          <= px_d;
      pend_alien_q  <= pend_alien_d;
      pend_player_q <= pend_player_d;
      pend_idx_q    <= pend_idx_d;
      pend_row_q    <= pend_row_d;
      pend_col_q    <= pend_col_d;
      alive_q       <= alive_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      hit_row_q     <= hit_row_d;
      hit_col_q     <= hit_col_d;
    end
  end

  // Pulses exist only in the RESOLVE cycle, so an async reset silences them immediately
  always_comb begin
    bullet_kill = (state_q == RESOLVE);
    alien_hit   = (state_q == RESOLVE) && pend_alien_q && !wave_reset;
    player_hit  = (state_q == RESOLVE) && pend_player_q;
    alive       = alive_q;
    score       = score_q;
    lives       = lives_q;
    hit_row     = hit_row_q;
    hit_col     = hit_col_q;
    all_dead    = (alive_q == '0);
    game_over   = (lives_q == 3'd0);
  end

endmodule

// File: tb/tb_bullet_hit_detector.sv
// tb/tb_bullet_hit_detector.sv - randomized self-checking bench for bullet_hit_detector
module tb_bullet_hit_detector;

  localparam int ROWS = 5;
  localparam int COLS = 11;
  localparam int N    = ROWS * COLS;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [9:0]   bullet_x, grid_x, player_x;
  logic [8:0]   bullet_y, grid_y;
  logic         bullet_active, bullet_dir, wave_reset;
  logic         bullet_kill, alien_hit, player_hit, all_dead, game_over;
  logic [2:0]   hit_row, lives;
  logic [3:0]   hit_col;
  logic [N-1:0] alive;
  logic [15:0]  score;

  int checks = 0;
  int failures = 0;

  bit m_alive[N];
  int m_score, m_lives, m_hr, m_hc;

  always #5 clk = ~clk;

  bullet_hit_detector dut (
    .clk(clk), .reset_n(reset_n),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active), .bullet_dir(bullet_dir),
    .grid_x(grid_x), .grid_y(grid_y), .player_x(player_x), .wave_reset(wave_reset),
    .bullet_kill(bullet_kill), .alien_hit(alien_hit), .hit_row(hit_row), .hit_col(hit_col),
    .player_hit(player_hit), .alive(alive), .score(score), .lives(lives),
    .all_dead(all_dead), .game_over(game_over)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_alive_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_alive[i];
    return v;
  endfunction

  function automatic bit model_all_dead();
    for (int i = 0; i < N; i++) if (m_alive[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
    m_score = 0;
    m_lives = 3;
    m_hr    = 0;
    m_hc    = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "/alive"},     64'(alive),     model_alive_vec());
    check({tag, "/score"},     64'(score),     64'(m_score));
    check({tag, "/lives"},     64'(lives),     64'(m_lives));
    check({tag, "/hit_row"},   64'(hit_row),   64'(m_hr));
    check({tag, "/hit_col"},   64'(hit_col),   64'(m_hc));
    check({tag, "/all_dead"},  64'(all_dead),  64'(model_all_dead()));
    check({tag, "/game_over"}, 64'(game_over), 64'(m_lives == 0));
  endtask

  task automatic check_pulses(input string tag, input bit ea, input bit ep, input bit ek);
    check(tag, 64'({alien_hit, player_hit, bullet_kill}), 64'({ea, ep, ek}));
  endtask

  // One bullet: sampled at the first edge, pulses expected after the second; hold keeps it active longer
  task automatic shot(input int bx, input int by, input bit dir, input bit wr, input int hold, input string tag);
    int dx, dy, col, row;
    bit ea = 1'b0;
    bit ep = 1'b0;
    int hidx = 0;
    if (m_lives > 0) begin
      if (dir) begin
        dx = bx - int'(grid_x);
        dy = by - int'(grid_y);
        if (dx >= 0 && dy >= 0) begin
          col = dx / 32;
          row = dy / 32;
          if (col < COLS && row < ROWS && (dx % 32) < 24 && (dy % 32) < 16) begin
            hidx = row * COLS + col;
            if (m_alive[hidx]) begin
              ea = 1'b1;
              m_hr = wr ? m_hr : row;
              m_hc = wr ? m_hc : col;
            end
          end
        end
      end else begin
        ep = (bx >= int'(player_x)) && (bx < int'(player_x) + 26) && (by >= 450) && (by < 466);
      end
    end
    @(negedge clk);
    bullet_x      = 10'(bx);
    bullet_y      = 9'(by);
    bullet_dir    = dir;
    bullet_active = 1'b1;
    @(negedge clk);
    check_pulses({tag, "/n+1"}, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    if (wr) wave_reset = 1'b1;
    #1;
    check_pulses({tag, "/n+2"}, ea && !wr, ep, ea || ep);
    if (hold == 0) bullet_active = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      wave_reset = 1'b0;
      check_pulses({tag, "/hold"}, 1'b0, 1'b0, 1'b0);
    end
    bullet_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wave_reset = 1'b0;
      check_pulses({tag, "/tail"}, 1'b0, 1'b0, 1'b0);
    end
    if (ea && !wr) begin
      m_alive[hidx] = 1'b0;
      m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
    end
    if (ep && m_lives > 0) m_lives--;
    if (wr) for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
    check_state(tag);
  endtask

  initial begin
    int bx, by;
    bit d, w;
    reset_n       = 1'b0;
    bullet_x      = '0;
    bullet_y      = '0;
    bullet_active = 1'b0;
    bullet_dir    = 1'b0;
    grid_x        = 10'd100;
    grid_y        = 9'd50;
    player_x      = 10'd300;
    wave_reset    = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    check_pulses("reset/pulses", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    shot(169, 85, 1'b1, 1'b0, 0, "kill_r1c2");
    shot(126, 55, 1'b1, 1'b0, 20, "gap_miss");
    shot(169, 85, 1'b1, 1'b0, 0, "dead_cell");
    shot(99, 60, 1'b1, 1'b0, 0, "left_of_grid");
    shot(100 + 11 * 32, 60, 1'b1, 1'b0, 0, "right_of_grid");
    shot(310, 455, 1'b0, 1'b0, 10, "player_hit");
    shot(201, 85, 1'b1, 1'b1, 0, "wave_in_resolve");
    shot(310, 455, 1'b0, 1'b0, 0, "player_hit2");
    shot(310, 455, 1'b0, 1'b0, 0, "player_hit3");
    shot(169, 85, 1'b1, 1'b0, 0, "game_over_frozen");

    // Async reset while parked in WAIT after a kill
    @(negedge clk);
    bullet_x = 10'd169; bullet_y = 9'd85; bullet_dir = 1'b1; bullet_active = 1'b1;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_state("async_reset");
    check_pulses("async_reset/pulses", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bullet_active = 1'b0;
    reset_n = 1'b1;
    shot(169, 85, 1'b1, 1'b0, 0, "after_reset");

    for (int t = 0; t < 200; t++) begin
      grid_x   = 10'($urandom_range(0, 300));
      grid_y   = 9'($urandom_range(0, 120));
      player_x = 10'($urandom_range(0, 600));
      d = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 7) == 0);
      if (d) begin
        bx = int'(grid_x) + int'($urandom_range(0, 11 * 32 + 40)) - 20;
        by = int'(grid_y) + int'($urandom_range(0, 5 * 32 + 40)) - 20;
      end else begin
        bx = int'(player_x) + int'($urandom_range(0, 40)) - 8;
        by = int'($urandom_range(440, 475));
      end
      if (bx < 0) bx = 0;
      if (bx > 1023) bx = 1023;
      if (by < 0) by = 0;
      if (by > 511) by = 511;
      shot(bx, by, d, w, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
